// File: rtl/sevenseg_pkg.sv
// Shared seven-segment glyph table and decoder (active-high, bit0=a .. bit6=g).
package sevenseg_pkg;

  localparam int unsigned SEG_W  = 7;
  localparam int unsigned HEX_W  = 4;
  localparam int unsigned GLYPHS = 16;
  localparam int unsigned BCNT_W = 8;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  localparam logic [SEG_W-1:0] SEG_GLYPH [GLYPHS] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_LOCKED = 1'b1
  } cap_state_e;

  typedef struct packed {
    logic             is_hex;
    logic [HEX_W-1:0] value;
  } seg_dec_t;

  // Reverse lookup of a normalised pattern into its hex value.
  function automatic seg_dec_t seg_decode(input logic [SEG_W-1:0] pattern);
    seg_dec_t r;
    r.is_hex = 1'b0;
    r.value  = '0;
    for (int i = 0; i < GLYPHS; i++) begin
      if (pattern == SEG_GLYPH[i]) begin
        r.is_hex = 1'b1;
        r.value  = HEX_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sevenseg_capture_seg_sync.sv
// Two-flop synchronizer with a caller-supplied asynchronous reset value.
module seg_sync #(
  parameter int unsigned W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] rst_val_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= rst_val_i;
      sync_q <= rst_val_i;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/sevenseg_capture.sv
// Seven-segment bus receiver: synchronise, debounce, and decode stable glyphs.
module sevenseg_capture #(
  parameter int unsigned STABLE_CYCLES = 25000,
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int unsigned CNT_W         = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] hex_in,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       blank,
  output logic       bad_pattern,
  output logic       digit_strobe,
  output logic [7:0] bad_count
);

  import sevenseg_pkg::*;

  localparam logic [CNT_W-1:0]  TERM_CNT  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [SEG_W-1:0]  RAW_OFF   = ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;
  localparam logic [BCNT_W-1:0] BCNT_MAX  = '1;

  logic [SEG_W-1:0] sync_raw;
  logic [SEG_W-1:0] sample_c;

  cap_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SEG_W-1:0]  prev_q, last_q, last_d;
  logic              first_q, first_d;
  logic [HEX_W-1:0]  digit_q, digit_d;
  logic              valid_q, valid_d;
  logic              blank_q, blank_d;
  logic              bad_q, bad_d;
  logic              strobe_q, strobe_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;

  logic              changed_c;
  logic              lock_c;
  logic              new_c;
  seg_dec_t          dec_c;

  seg_sync #(.W(SEG_W)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .rst_val_i (RAW_OFF),
    .d_i       (hex_in),
    .q_o       (sync_raw)
  );

  assign sample_c = ACTIVE_LOW ? ~sync_raw : sync_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_SETTLE;
      cnt_q    <= '0;
      prev_q   <= SEG_BLANK;
      last_q   <= SEG_BLANK;
      first_q  <= 1'b1;
      digit_q  <= '0;
      valid_q  <= 1'b0;
      blank_q  <= 1'b0;
      bad_q    <= 1'b0;
      strobe_q <= 1'b0;
      bcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prev_q   <= sample_c;
      last_q   <= last_d;
      first_q  <= first_d;
      digit_q  <= digit_d;
      valid_q  <= valid_d;
      blank_q  <= blank_d;
      bad_q    <= bad_d;
      strobe_q <= strobe_d;
      bcnt_q   <= bcnt_d;
    end
  end

  // Settle/lock FSM plus lock-time flag update; flags only move on a lock.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    first_d   = first_q;
    digit_d   = digit_q;
    valid_d   = valid_q;
    blank_d   = blank_q;
    bad_d     = bad_q;
    strobe_d  = 1'b0;
    bcnt_d    = bcnt_q;
    lock_c    = 1'b0;
    changed_c = (sample_c != prev_q);
    dec_c     = seg_decode(sample_c);
    new_c     = first_q || (sample_c != last_q);

    unique case (state_q)
      ST_SETTLE: begin
        if (changed_c) begin
          cnt_d = '0;
        end else if (cnt_q == TERM_CNT) begin
          lock_c  = 1'b1;
          state_d = ST_LOCKED;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LOCKED: begin
        if (changed_c) begin
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_SETTLE;
      end
    endcase

    if (lock_c) begin
      strobe_d = new_c;
      first_d  = 1'b0;
      last_d   = sample_c;
      if (dec_c.is_hex) begin
        digit_d = dec_c.value;
        valid_d = 1'b1;
        blank_d = 1'b0;
        bad_d   = 1'b0;
      end else if (sample_c == SEG_BLANK) begin
        valid_d = 1'b0;
        blank_d = 1'b1;
        bad_d   = 1'b0;
      end else begin
        valid_d = 1'b0;
        blank_d = 1'b0;
        bad_d   = 1'b1;
        // A silent re-lock of the same bad glyph is not a new error.
        if (new_c && (bcnt_q != BCNT_MAX)) begin
          bcnt_d = bcnt_q + BCNT_W'(1);
        end
      end
    end
  end

  assign digit        = digit_q;
  assign digit_valid  = valid_q;
  assign blank        = blank_q;
  assign bad_pattern  = bad_q;
  assign digit_strobe = strobe_q;
  assign bad_count    = bcnt_q;

endmodule
